mem_512x8: RTL and testbench



---
 rtl/mem_512x8_pkg.sv | 9 +
 rtl/mem_512x8_if.sv | 31 +++
 rtl/mem_512x8.sv | 40 ++++
 tb/tb_mem_512x8.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_512x8_pkg.sv
// Shared sizing constants for the 8-bit datapath memory.
// Ports: none (package used by the memory, its interface and the datapath).
package mem_pkg;

   localparam int MEM_DATA_W = 8;
   localparam int MEM_ADDR_W = 9;
   localparam int MEM_DEPTH  = 2 ** MEM_ADDR_W;

endpackage

// File: rtl/mem_512x8_if.sv
// Bus bundle for the 512x8 data memory port.
// Ports: address, data_in, WE, RE, Enable (master drives), data_out (slave drives).
interface mem_512x8_if;
   import mem_pkg::*;

   logic [MEM_ADDR_W-1:0] address;
   logic [MEM_DATA_W-1:0] data_in;
   logic                  WE;
   logic                  RE;
   logic                  Enable;
   logic [MEM_DATA_W-1:0] data_out;

   modport master (
      output address,
      output data_in,
      output WE,
      output RE,
      output Enable,
      input  data_out
   );

   modport slave (
      input  address,
      input  data_in,
      input  WE,
      input  RE,
      input  Enable,
      output data_out
   );

endinterface

// File: rtl/mem_512x8.sv
// Single-port synchronous 512x8 memory, write-first, registered output.
// Ports: clk, rst (async active-high), bus (slave side of mem_512x8_if).
module mem_512x8
   import mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   mem_512x8_if.slave  bus
);

   logic [MEM_DATA_W-1:0] array [0:MEM_DEPTH-1];
   logic [MEM_DATA_W-1:0] data_q;
   logic                  wr;
   logic                  rd;

   // WE wins over RE; Enable gates both.
   assign wr = bus.Enable & bus.WE;
   assign rd = bus.Enable & ~bus.WE & bus.RE;

   // No reset on the array so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr) begin
         array[bus.address] <= bus.data_in;
      end
   end

   // Write-first: a write also forwards data_in to the output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (wr) begin
         data_q <= bus.data_in;
      end else if (rd) begin
         data_q <= array[bus.address];
      end
   end

   assign bus.data_out = data_q;

endmodule

// File: tb/tb_mem_512x8.sv
// Self-checking bench for mem_512x8: vector table, reset corners, random soak.
// Ports: none.
module tb_mem_512x8;
   import mem_pkg::*;

   typedef struct {
      logic       en;
      logic       we;
      logic       re;
      logic [8:0] addr;
      logic [7:0] din;
      logic [7:0] exp;
      string      name;
   } vec_t;

   typedef struct {
      logic [7:0] val;
      bit         known;
      string      name;
   } sb_t;

   logic clk;
   logic rst;

   mem_512x8_if bus ();

   mem_512x8 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         tests;
   int         fails;
   sb_t        sbq[$];
   vec_t       vecs[$];
   logic [7:0] model [int];
   logic [7:0] cur_exp;
   bit         cur_known;

   task automatic check(input string nm, input logic [7:0] exp);
      tests++;
      if (bus.data_out !== exp) begin
         fails++;
         $display("FAIL %s: data_out=%h expected=%h", nm, bus.data_out, exp);
      end
   endtask

   // One clock: drive at negedge, predict, then compare just after posedge.
   task automatic drive(input logic r, input logic en, input logic we,
                        input logic re, input logic [8:0] a,
                        input logic [7:0] d, input bit has_exp,
                        input logic [7:0] texp, input string nm);
      sb_t e;
      @(negedge clk);
      rst            = r;
      bus.Enable     = en;
      bus.WE         = we;
      bus.RE         = re;
      bus.address    = a;
      bus.data_in    = d;
      if (r) begin
         if (en && we) model.delete(int'(a));
         cur_exp   = 8'h00;
         cur_known = 1'b1;
      end else if (en && we) begin
         model[int'(a)] = d;
         cur_exp        = d;
         cur_known      = 1'b1;
      end else if (en && re) begin
         if (model.exists(int'(a))) begin
            cur_exp   = model[int'(a)];
            cur_known = 1'b1;
         end else begin
            cur_known = 1'b0;
         end
      end
      e.val   = has_exp ? texp : cur_exp;
      e.known = has_exp ? 1'b1 : cur_known;
      e.name  = nm;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      if (e.known) check(e.name, e.val);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      cur_exp = 8'h00;
      cur_known = 1'b1;
      rst = 1'b1;
      bus.Enable  = 1'b0;
      bus.WE      = 1'b0;
      bus.RE      = 1'b0;
      bus.address = '0;
      bus.data_in = '0;
      #1;
      check("reset_state", 8'h00);
      drive(1, 1, 0, 1, 9'h000, 8'h00, 1, 8'h00, "reset_hold");

      vecs.push_back('{1, 1, 0, 9'h1C3, 8'h5A, 8'h5A, "write_first"});
      vecs.push_back('{1, 1, 0, 9'h000, 8'h3C, 8'h3C, "wr_000"});
      vecs.push_back('{1, 1, 0, 9'h1FF, 8'hC3, 8'hC3, "wr_1ff"});
      vecs.push_back('{1, 0, 1, 9'h000, 8'hEE, 8'h3C, "rd_000"});
      vecs.push_back('{1, 0, 1, 9'h1FF, 8'hEE, 8'hC3, "rd_1ff"});
      vecs.push_back('{1, 0, 1, 9'h1C3, 8'h00, 8'h5A, "rd_1c3"});
      vecs.push_back('{1, 1, 0, 9'h010, 8'h11, 8'h11, "wr_010"});
      vecs.push_back('{1, 0, 1, 9'h000, 8'h00, 8'h3C, "rd_000b"});
      vecs.push_back('{0, 1, 0, 9'h010, 8'hFF, 8'h3C, "en0_write"});
      vecs.push_back('{0, 0, 1, 9'h1FF, 8'hFF, 8'h3C, "en0_read"});
      vecs.push_back('{1, 0, 1, 9'h010, 8'h00, 8'h11, "rd_010"});
      vecs.push_back('{1, 0, 0, 9'h1FF, 8'h77, 8'h11, "idle"});
      vecs.push_back('{1, 1, 0, 9'h020, 8'h22, 8'h22, "wr_020"});
      vecs.push_back('{1, 0, 1, 9'h000, 8'h00, 8'h3C, "rd_000c"});
      vecs.push_back('{1, 1, 1, 9'h020, 8'h99, 8'h99, "we_re"});
      vecs.push_back('{1, 0, 1, 9'h010, 8'h00, 8'h11, "rd_010b"});
      vecs.push_back('{1, 0, 1, 9'h020, 8'h00, 8'h99, "rd_020"});

      for (int i = 0; i < vecs.size(); i++) begin
         drive(0, vecs[i].en, vecs[i].we, vecs[i].re, vecs[i].addr,
               vecs[i].din, 1, vecs[i].exp, vecs[i].name);
      end

      // Async reset mid-cycle after output shows A5.
      drive(0, 1, 1, 0, 9'h030, 8'hA5, 1, 8'hA5, "wr_a5");
      rst = 1'b1;
      #1;
      check("rst_async", 8'h00);
      drive(1, 1, 0, 1, 9'h030, 8'h00, 1, 8'h00, "rst_held_rd");
      drive(1, 1, 1, 0, 9'h100, 8'h77, 1, 8'h00, "rst_coinc_wr");
      drive(0, 1, 1, 0, 9'h050, 8'h6B, 1, 8'h6B, "rst_release");
      drive(0, 1, 0, 1, 9'h030, 8'h00, 1, 8'hA5, "rd_030");
      drive(0, 1, 0, 1, 9'h000, 8'h00, 1, 8'h3C, "rd_000d");

      for (int i = 0; i < 1000; i++) begin
         logic [8:0] a;
         if ($urandom_range(0, 1) == 0) a = 9'($urandom_range(0, 63));
         else a = 9'($urandom_range(0, MEM_DEPTH - 1));
         drive(0, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)),
               0, 8'h00, "soak");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
